// File: rtl/fdc_mockdrive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdc_mockdrive_pkg
// Description : Shared constants, image geometry type and timing helpers for
//               the mock floppy drive array.
// Revision    : 1.0 - initial release
// ============================================================================
package fdc_mockdrive_pkg;

    localparam int DIV_W = 8;   // byte-rate divider width
    localparam int POS_W = 9;   // byte position within a slot

    // clk_3mhz_en ticks minus 1 per byte
    localparam logic [DIV_W-1:0] SD_RELOAD   = 8'd186;
    localparam logic [DIV_W-1:0] DD_RELOAD   = 8'd93;

    // Byte offset of the header / index pulse inside a slot
    localparam logic [POS_W-1:0] HDR_OFS     = 9'd8;

    // Last byte index of a data sector slot and of the index-gap slot
    localparam logic [POS_W-1:0] SD_SEC_LAST = 9'd324;
    localparam logic [POS_W-1:0] DD_SEC_LAST = 9'd350;
    localparam logic [POS_W-1:0] SD_GAP_LAST = 9'd251;
    localparam logic [POS_W-1:0] DD_GAP_LAST = 9'd131;

    // Attributes of a mounted disk image
    typedef struct packed {
        logic       mounted;
        logic       ds;
        logic       dd;
        logic       wp;
        logic [4:0] sps;
    } geom_t;

    // Divider reload value for the image density
    function automatic logic [DIV_W-1:0] byte_reload(input logic dd);
        return dd ? DD_RELOAD : SD_RELOAD;
    endfunction

    // Last byte index of the current slot (gap or data) for the density
    function automatic logic [POS_W-1:0] slot_last(input logic dd, input logic gap);
        logic [POS_W-1:0] v;
        if (gap) begin
            v = dd ? DD_GAP_LAST : SD_GAP_LAST;
        end else begin
            v = dd ? DD_SEC_LAST : SD_SEC_LAST;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fdc_mockdrive_if.sv
`default_nettype none
// ============================================================================
// Module      : fdc_mockdrive_if
// Description : Drive-select bus between the FDC core (master) and the mock
//               drive array (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fdc_mockdrive_if #(
    parameter int DRV_W   = 2,
    parameter int TRACK_W = 7
);
    // FDC -> drives
    logic [DRV_W-1:0]   sel;
    logic               sel_valid;
    logic               motor_on;
    logic               step;
    logic               dir;

    // Drives -> FDC (selected drive)
    logic               ready;
    logic               byte_clk;
    logic               header_clk;
    logic               ip;
    logic [TRACK_W-1:0] track;
    logic [4:0]         sector;
    logic               ds;
    logic               tr00;
    logic               wprt;

    modport master (
        output sel, sel_valid, motor_on, step, dir,
        input  ready, byte_clk, header_clk, ip, track, sector, ds, tr00, wprt
    );

    modport slave (
        input  sel, sel_valid, motor_on, step, dir,
        output ready, byte_clk, header_clk, ip, track, sector, ds, tr00, wprt
    );
endinterface
`default_nettype wire

// File: rtl/fdc_mockdrive_unit.sv
`default_nettype none
// ============================================================================
// Module      : fdc_mockdrive_unit
// Description : One mock drive: head position, byte clock, sector slot
//               sequencing, index/header pulses and spin-up qualification.
// Revision    : 1.0 - initial release
// ============================================================================
module fdc_mockdrive_unit
    import fdc_mockdrive_pkg::*;
#(
    parameter int TRACK_W    = 7,
    parameter int MAX_TRACK  = 80,
    parameter int SPINUP_IDX = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_clk_3mhz_en,
    input  wire logic               i_motor_on,
    input  wire logic               i_step_pulse,
    input  wire logic               i_dir,
    input  wire logic               i_load,
    input  wire geom_t              i_load_geom,
    output logic [TRACK_W-1:0]      o_track,
    output logic [4:0]              o_sector,
    output logic                    o_byte_clk,
    output logic                    o_header_clk,
    output logic                    o_ip,
    output logic                    o_ready,
    output logic                    o_ds,
    output logic                    o_wprt
);

    localparam int                 c_SPIN_W    = (SPINUP_IDX < 1) ? 1 : $clog2(SPINUP_IDX + 1);
    localparam logic [c_SPIN_W-1:0] c_SPIN_MAX = c_SPIN_W'(SPINUP_IDX);
    localparam logic [TRACK_W-1:0]  c_TRACK_TOP = TRACK_W'(MAX_TRACK - 1);

    logic [TRACK_W-1:0]  r_track;
    geom_t               r_geom;
    logic [DIV_W-1:0]    r_div;
    logic [POS_W-1:0]    r_pos;
    logic [4:0]          r_sector;
    logic [c_SPIN_W-1:0] r_spin;
    logic                r_byte_clk;
    logic                r_header_clk;
    logic                r_ip_pre;
    logic                r_ip;

    logic                w_run;
    logic                w_byte_evt;
    logic                w_gap;
    logic                w_at_hdr;
    logic [POS_W-1:0]    w_pos_last;

    assign w_run      = r_geom.mounted & i_motor_on;
    assign w_byte_evt = w_run & i_clk_3mhz_en & (r_div == '0);
    // sps=0 makes every slot the gap
    assign w_gap      = (r_sector >= r_geom.sps);
    assign w_at_hdr   = (r_pos == HDR_OFS);
    assign w_pos_last = slot_last(r_geom.dd, w_gap);

    // Head position: one track per step pulse, clamped to the physical range
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_track <= '0;
        end else if (i_step_pulse) begin
            if (i_dir) begin
                if (r_track != c_TRACK_TOP) begin
                    r_track <= r_track + 1'b1;
                end
            end else if (r_track != '0) begin
                r_track <= r_track - 1'b1;
            end
        end
    end

    // Image attributes latched by the mount logic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_geom <= '0;
        end else if (i_load) begin
            r_geom <= i_load_geom;
        end
    end

    // Byte-rate divider; a load restarts it so the first byte comes promptly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_byte_clk <= 1'b0;
        end else if (i_load) begin
            r_div      <= '0;
            r_byte_clk <= 1'b0;
        end else begin
            r_byte_clk <= w_byte_evt;
            if (w_run && i_clk_3mhz_en) begin
                r_div <= (r_div == '0) ? byte_reload(r_geom.dd) : r_div - 1'b1;
            end
        end
    end

    // Slot sequencing: each byte strobe handles byte r_pos, then advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pos        <= '0;
            r_sector     <= '0;
            r_header_clk <= 1'b0;
            r_ip_pre     <= 1'b0;
        end else if (i_load) begin
            r_pos        <= '0;
            r_sector     <= '0;
            r_header_clk <= 1'b0;
            r_ip_pre     <= 1'b0;
        end else begin
            r_header_clk <= w_byte_evt & w_at_hdr & ~w_gap;
            r_ip_pre     <= w_byte_evt & w_at_hdr & w_gap;
            if (w_byte_evt) begin
                if (r_pos == w_pos_last) begin
                    r_pos    <= '0;
                    r_sector <= w_gap ? 5'd0 : r_sector + 5'd1;
                end else begin
                    r_pos <= r_pos + 1'b1;
                end
            end
        end
    end

    // Index pulse trails the gap's header byte by one cycle; spin-up counts them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ip   <= 1'b0;
            r_spin <= '0;
        end else begin
            r_ip <= i_load ? 1'b0 : r_ip_pre;
            if (i_load || !i_motor_on || !r_geom.mounted) begin
                r_spin <= '0;
            end else if (r_ip && (r_spin != c_SPIN_MAX)) begin
                r_spin <= r_spin + 1'b1;
            end
        end
    end

    assign o_track      = r_track;
    assign o_sector     = w_gap ? 5'd0 : r_sector;
    assign o_byte_clk   = r_byte_clk;
    assign o_header_clk = r_header_clk;
    assign o_ip         = r_ip;
    assign o_ready      = r_geom.mounted & (r_spin == c_SPIN_MAX);
    assign o_ds         = r_geom.ds;
    assign o_wprt       = r_geom.wp;

endmodule
`default_nettype wire

// File: rtl/fdc_mockdrive_array.sv
`default_nettype none
// ============================================================================
// Module      : fdc_mockdrive_array
// Description : NUM_DRIVES independent mock floppy drives behind one FDC
//               drive-select bus, with shared step edge detection and a
//               selected-drive output multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module fdc_mockdrive_array
    import fdc_mockdrive_pkg::*;
#(
    parameter int NUM_DRIVES = 3,
    parameter int DRV_W      = 2,
    parameter int TRACK_W    = 7,
    parameter int MAX_TRACK  = 80,
    parameter int SPINUP_IDX = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clk_3mhz_en,
    fdc_mockdrive_if.slave        bus,
    input  wire logic [DRV_W-1:0] load_drive,
    input  wire logic             load_mounted,
    input  wire logic             load_ds,
    input  wire logic             load_dd,
    input  wire logic             load_wp,
    input  wire logic [4:0]       load_sps,
    input  wire logic             load_strobe
);

    logic                  r_step_last;
    logic                  w_step_fall;
    geom_t                 w_load_geom;
    logic [NUM_DRIVES-1:0] w_sel_hit;
    logic [NUM_DRIVES-1:0] w_load_hit;

    logic [TRACK_W-1:0]    w_track_d  [NUM_DRIVES];
    logic [4:0]            w_sector_d [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] w_byte_d;
    logic [NUM_DRIVES-1:0] w_hdr_d;
    logic [NUM_DRIVES-1:0] w_ip_d;
    logic [NUM_DRIVES-1:0] w_ready_d;
    logic [NUM_DRIVES-1:0] w_ds_d;
    logic [NUM_DRIVES-1:0] w_wp_d;

    logic                  w_ready;
    logic                  w_byte_clk;
    logic                  w_header_clk;
    logic                  w_ip;
    logic [TRACK_W-1:0]    w_track;
    logic [4:0]            w_sector;
    logic                  w_ds;
    logic                  w_tr00;
    logic                  w_wprt;

    assign w_load_geom.mounted = load_mounted;
    assign w_load_geom.ds      = load_ds;
    assign w_load_geom.dd      = load_dd;
    assign w_load_geom.wp      = load_wp;
    assign w_load_geom.sps     = load_sps;

    // Step edge detector shared by all drives; only the selected one moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_last <= 1'b0;
        end else begin
            r_step_last <= bus.step;
        end
    end

    assign w_step_fall = r_step_last & ~bus.step;

    generate
        for (genvar gi = 0; gi < NUM_DRIVES; gi++) begin : g_drive
            assign w_sel_hit[gi]  = bus.sel_valid & (bus.sel == DRV_W'(gi));
            assign w_load_hit[gi] = load_strobe & (load_drive == DRV_W'(gi));

            fdc_mockdrive_unit #(
                .TRACK_W    (TRACK_W),
                .MAX_TRACK  (MAX_TRACK),
                .SPINUP_IDX (SPINUP_IDX)
            ) u_unit (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_clk_3mhz_en(clk_3mhz_en),
                .i_motor_on   (bus.motor_on),
                .i_step_pulse (w_step_fall & w_sel_hit[gi]),
                .i_dir        (bus.dir),
                .i_load       (w_load_hit[gi]),
                .i_load_geom  (w_load_geom),
                .o_track      (w_track_d[gi]),
                .o_sector     (w_sector_d[gi]),
                .o_byte_clk   (w_byte_d[gi]),
                .o_header_clk (w_hdr_d[gi]),
                .o_ip         (w_ip_d[gi]),
                .o_ready      (w_ready_d[gi]),
                .o_ds         (w_ds_d[gi]),
                .o_wprt       (w_wp_d[gi])
            );
        end
    endgenerate

    // Output mux: an invalid or out-of-range selection matches no drive -> all 0
    always_comb begin
        w_ready      = 1'b0;
        w_byte_clk   = 1'b0;
        w_header_clk = 1'b0;
        w_ip         = 1'b0;
        w_track      = '0;
        w_sector     = '0;
        w_ds         = 1'b0;
        w_tr00       = 1'b0;
        w_wprt       = 1'b0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (w_sel_hit[i]) begin
                w_ready      = w_ready_d[i];
                w_byte_clk   = w_byte_d[i];
                w_header_clk = w_hdr_d[i];
                w_ip         = w_ip_d[i];
                w_track      = w_track_d[i];
                w_sector     = w_sector_d[i];
                w_ds         = w_ds_d[i];
                w_tr00       = (w_track_d[i] == '0);
                w_wprt       = w_wp_d[i];
            end
        end
    end

    assign bus.ready      = w_ready;
    assign bus.byte_clk   = w_byte_clk;
    assign bus.header_clk = w_header_clk;
    assign bus.ip         = w_ip;
    assign bus.track      = w_track;
    assign bus.sector     = w_sector;
    assign bus.ds         = w_ds;
    assign bus.tr00       = w_tr00;
    assign bus.wprt       = w_wprt;

endmodule
`default_nettype wire
